// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types, widths and helpers for the rPLL lock supervisor.
package pll_sup_pkg;

  localparam int PSDA_W  = 4;
  localparam int RETRY_W = 8;

  typedef logic [1:0] pll_state_t;

  localparam pll_state_t S_PRST  = 2'd0;
  localparam pll_state_t S_WAIT  = 2'd1;
  localparam pll_state_t S_RUN   = 2'd2;
  localparam pll_state_t S_PHASE = 2'd3;

  // Width that can hold the largest cycle count, including the count value itself.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Phase-step request/acknowledge handshake and the PSDA value it controls.
interface pll_lock_supervisor_if;
  import pll_sup_pkg::*;

  logic              phase_req;
  logic              phase_dir;
  logic              phase_ack;
  logic [PSDA_W-1:0] pll_psda;

  modport master (output phase_req, output phase_dir, input phase_ack, input pll_psda);
  modport slave  (input phase_req, input phase_dir, output phase_ack, output pll_psda);

endinterface

// File: rtl/pll_lock_supervisor_sync.sv
// Two-flop synchronizer bringing the asynchronous rPLL LOCK into the clkin domain.
module pll_lock_sync (
  input  logic clkin,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clkin) begin
    if (reset) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rPLL reset/lock sequencer with downstream reset release and PSDA phase stepping.
// Phase stepping is built only when PLL_SUP_PHASE_EN is defined.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int                RST_CYCLES     = 16,
  parameter int                STABLE_CYCLES  = 1024,
  parameter int                TIMEOUT_CYCLES = 27000,
  parameter int                SETTLE_CYCLES  = 64,
  parameter logic [PSDA_W-1:0] PSDA_INIT      = 4'b0000
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               pll_lock,
  output logic               pll_reset,
  output logic               rst_out,
  output logic               ready,
  output logic [RETRY_W-1:0] retry_cnt,
  pll_lock_supervisor_if.slave phase_if
);

  localparam int CNT_W = cnt_width(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES, SETTLE_CYCLES);

  pll_state_t       state;
  pll_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] stable_cnt;
  logic             lock_s;
  logic             ack;
  logic             phase_go;

  pll_lock_sync u_sync (
    .clkin    (clkin),
    .reset    (reset),
    .async_in (pll_lock),
    .sync_out (lock_s)
  );

  assign phase_go = phase_if.phase_req && !ack;

  // Reaching stability beats a simultaneous timeout; lock loss beats any phase activity.
  always_comb begin
    state_nxt = state;
    case (state)
      S_PRST:
        if (cnt == CNT_W'(RST_CYCLES - 1)) state_nxt = S_WAIT;
      S_WAIT:
        if (stable_cnt == CNT_W'(STABLE_CYCLES))       state_nxt = S_RUN;
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1))   state_nxt = S_PRST;
      S_RUN:
`ifdef PLL_SUP_PHASE_EN
        if (!lock_s)       state_nxt = S_PRST;
        else if (phase_go) state_nxt = S_PHASE;
      S_PHASE:
        if (!lock_s)                                 state_nxt = S_PRST;
        else if (cnt == CNT_W'(SETTLE_CYCLES - 1))   state_nxt = S_RUN;
`else
        if (!lock_s) state_nxt = S_PRST;
`endif
      default:
        state_nxt = S_PRST;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state      <= S_PRST;
      cnt        <= '0;
      stable_cnt <= '0;
      retry_cnt  <= '0;
      ack        <= 1'b0;
      pll_reset  <= 1'b1;
      rst_out    <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == S_RUN) cnt <= '0;
      else                                      cnt <= cnt + CNT_W'(1);
      if (state == S_WAIT && state_nxt == S_WAIT && lock_s) stable_cnt <= stable_cnt + CNT_W'(1);
      else                                                  stable_cnt <= '0;
      if (state == S_WAIT && state_nxt == S_PRST && retry_cnt != '1)
        retry_cnt <= retry_cnt + RETRY_W'(1);
`ifdef PLL_SUP_PHASE_EN
      ack <= (state == S_PHASE) && (state_nxt == S_RUN);
`else
      ack <= (state == S_RUN) && (state_nxt == S_RUN) && phase_go;
`endif
      pll_reset <= (state_nxt == S_PRST);
      rst_out   <= (state_nxt == S_PRST) || (state_nxt == S_WAIT);
    end
  end

`ifdef PLL_SUP_PHASE_EN
  logic [PSDA_W-1:0] psda;

  always_ff @(posedge clkin) begin
    if (reset) begin
      psda <= PSDA_INIT;
    end else if (state == S_RUN && state_nxt == S_PHASE) begin
      psda <= phase_if.phase_dir ? psda + PSDA_W'(1) : psda - PSDA_W'(1);
    end
  end

  assign phase_if.pll_psda = psda;
`else
  logic unused_dir;
  assign unused_dir        = phase_if.phase_dir;
  assign phase_if.pll_psda = PSDA_INIT;
`endif

  assign phase_if.phase_ack = ack;
  assign ready              = !rst_out;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor with shortened cycle parameters.
module tb_pll_lock_supervisor;

  logic       clkin = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       pll_reset;
  logic       rst_out;
  logic       ready;
  logic [7:0] retry_cnt;
  int         num_compared = 0;
  int         num_mismatched = 0;

  pll_lock_supervisor_if phase_if ();

  pll_lock_supervisor #(
    .RST_CYCLES     (4),
    .STABLE_CYCLES  (8),
    .TIMEOUT_CYCLES (64),
    .SETTLE_CYCLES  (4),
    .PSDA_INIT      (4'd15)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .rst_out   (rst_out),
    .ready     (ready),
    .retry_cnt (retry_cnt),
    .phase_if  (phase_if)
  );

  always #5 clkin = ~clkin;

  task automatic applyStimulus(input logic rst, input logic lock, input logic req, input logic dir);
    reset              = rst;
    pll_lock           = lock;
    phase_if.phase_req = req;
    phase_if.phase_dir = dir;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_compared++;
    if (got !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    applyStimulus(1, 0, 0, 0);
    step(3);
    checkOutput("rst_pll_reset", pll_reset, 1);
    checkOutput("rst_rst_out", rst_out, 1);
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_ack", phase_if.phase_ack, 0);
    checkOutput("rst_retry", retry_cnt, 0);
    checkOutput("rst_psda", phase_if.pll_psda, 15);

    // Normal lock: PLL reset for cycles 0-3, release 11 cycles after lock rises at cycle 10
    applyStimulus(0, 0, 0, 0);
    step(3);
    checkOutput("prst_cyc3", pll_reset, 1);
    step(1);
    checkOutput("prst_end", pll_reset, 0);
    checkOutput("wait_rst_out", rst_out, 1);
    step(6);
    applyStimulus(0, 1, 0, 0);
    step(10);
    checkOutput("lock_early", rst_out, 1);
    step(1);
    checkOutput("lock_release", rst_out, 0);
    checkOutput("lock_ready", ready, 1);
    checkOutput("lock_retry", retry_cnt, 0);

    // Glitchy lock: high 5, low 1, high again; release 11 after the second rise
    applyStimulus(1, 0, 0, 0);
    step(1);
    applyStimulus(0, 0, 0, 0);
    step(10);
    applyStimulus(0, 1, 0, 0);
    step(5);
    applyStimulus(0, 0, 0, 0);
    step(1);
    applyStimulus(0, 1, 0, 0);
    step(10);
    checkOutput("glitch_early", rst_out, 1);
    step(1);
    checkOutput("glitch_release", rst_out, 0);

    // Phase step +1 from 15 wraps to 0; a held request is ignored while ack is high
    applyStimulus(0, 1, 1, 1);
    step(1);
`ifdef PLL_SUP_PHASE_EN
    checkOutput("up_psda", phase_if.pll_psda, 0);
    checkOutput("up_ack_early", phase_if.phase_ack, 0);
    step(3);
    checkOutput("up_ack_settle", phase_if.phase_ack, 0);
    step(1);
    checkOutput("up_ack", phase_if.phase_ack, 1);
    step(1);
    checkOutput("ack_ignore", phase_if.phase_ack, 0);
    checkOutput("psda_ignore", phase_if.pll_psda, 0);
`else
    checkOutput("up_ack", phase_if.phase_ack, 1);
    checkOutput("up_psda", phase_if.pll_psda, 15);
    step(1);
    checkOutput("ack_ignore", phase_if.phase_ack, 0);
`endif
    applyStimulus(0, 1, 0, 1);
    step(1);

    // Phase step -1 from 0 wraps to 15
    applyStimulus(0, 1, 1, 0);
    step(1);
`ifdef PLL_SUP_PHASE_EN
    checkOutput("dn_psda", phase_if.pll_psda, 15);
    step(4);
    checkOutput("dn_ack", phase_if.phase_ack, 1);
`else
    checkOutput("dn_ack", phase_if.phase_ack, 1);
    checkOutput("dn_psda", phase_if.pll_psda, 15);
`endif
    applyStimulus(0, 1, 0, 0);
    step(1);
    checkOutput("dn_ack_drop", phase_if.phase_ack, 0);

    // Lock loss (mid-settle when stepping exists); pending request served after relock
`ifdef PLL_SUP_PHASE_EN
    applyStimulus(0, 1, 1, 1);
    step(1);
    checkOutput("loss_psda_step", phase_if.pll_psda, 0);
    applyStimulus(0, 0, 1, 1);
`else
    applyStimulus(0, 0, 0, 0);
`endif
    step(2);
    checkOutput("loss_hold", rst_out, 0);
    step(1);
    checkOutput("loss_rst_out", rst_out, 1);
    checkOutput("loss_pll_reset", pll_reset, 1);
    checkOutput("loss_noack", phase_if.phase_ack, 0);
`ifdef PLL_SUP_PHASE_EN
    checkOutput("loss_psda_keep", phase_if.pll_psda, 0);
    applyStimulus(0, 1, 1, 1);
`else
    checkOutput("loss_psda_keep", phase_if.pll_psda, 15);
    applyStimulus(0, 1, 0, 0);
`endif
    step(12);
    checkOutput("relock_early", rst_out, 1);
    step(1);
    checkOutput("relock_release", rst_out, 0);
`ifdef PLL_SUP_PHASE_EN
    step(1);
    checkOutput("pending_psda", phase_if.pll_psda, 1);
    step(4);
    checkOutput("pending_ack", phase_if.phase_ack, 1);
    applyStimulus(0, 1, 0, 1);
    step(1);
`endif

    // No lock: a PLL reset pulse every 68 cycles and a saturating retry count
    applyStimulus(1, 0, 0, 0);
    step(1);
    applyStimulus(0, 0, 0, 0);
    step(67);
    checkOutput("tmo_before", pll_reset, 0);
    checkOutput("tmo_retry0", retry_cnt, 0);
    step(1);
    checkOutput("tmo_prst", pll_reset, 1);
    checkOutput("retry_1", retry_cnt, 1);
    step(4);
    checkOutput("tmo_prst_end", pll_reset, 0);
    step(64);
    checkOutput("tmo_prst2", pll_reset, 1);
    checkOutput("retry_2", retry_cnt, 2);
    step(68);
    checkOutput("retry_3", retry_cnt, 3);
    step(68 * 251);
    checkOutput("retry_254", retry_cnt, 254);
    step(68);
    checkOutput("retry_255", retry_cnt, 255);
    step(68);
    checkOutput("retry_sat", retry_cnt, 255);
    checkOutput("tmo_rst_out", rst_out, 1);

    // Relock after saturation, then reset mid-operation in S_RUN
    applyStimulus(0, 1, 0, 0);
    step(12);
    checkOutput("relock2_early", rst_out, 1);
    step(1);
    checkOutput("relock2_release", rst_out, 0);
    checkOutput("relock2_retry", retry_cnt, 255);
    applyStimulus(1, 1, 0, 0);
    step(1);
    checkOutput("midrst_pll_reset", pll_reset, 1);
    checkOutput("midrst_rst_out", rst_out, 1);
    checkOutput("midrst_ready", ready, 0);
    checkOutput("midrst_psda", phase_if.pll_psda, 15);
    checkOutput("midrst_retry", retry_cnt, 0);
    checkOutput("midrst_ack", phase_if.phase_ack, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
